dac_load_arbiter: RTL and testbench
===================================

Name: dac_load_arbiter

Overview:
- Shares the single TLV5618 DAC load controller between three requesters.
- Requester 0: host/USB slow-control register writes. Requester 1: threshold-scan sequencer. Requester 2: calibration logic.
- Round-robin arbitration. Issues one load per grant on the controller's start/select/data interface and waits for its done pulse, with a timeout.
- Keeps shadow copies of the last value loaded into each DAC channel, for readback.

Parameters:
- TIMEOUT_CYCLES, 4096: Clk cycles to wait for DacLoadDone before aborting a grant (min 16).
- TIMEOUT_WIDTH, 13: width of the timeout counter; must satisfy 2^TIMEOUT_WIDTH > TIMEOUT_CYCLES.

Ports:
- Clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- Enable  input  1  1 = arbitration allowed; 0 = no new grants (an in-flight load completes)
- ReqValid  input  3  per-requester request; held high until that requester's ReqDone
- ReqSelect  input  6  2 bits per requester [2i+1:2i]: 01 = DAC1, 10 = DAC2, 11 = both, 00 = illegal
- ReqDac1Data  input  36  12 bits per requester [12i+11:12i]
- ReqDac2Data  input  36  12 bits per requester
- ReqDone  output  3  one-cycle completion pulse per requester
- ReqError  output  3  one-cycle pulse coincident with ReqDone: illegal select or timeout
- DacLoadStart  output  1  one-cycle start pulse to the DAC load controller
- LoadDacSelect  output  2  select to the controller; stable from ISSUE until return to IDLE
- Dac1Data  output  12  channel-A data to the controller; stable like LoadDacSelect
- Dac2Data  output  12  channel-B data to the controller; stable like LoadDacSelect
- DacLoadDone  input  1  one-cycle done pulse from the controller
- Busy  output  1  high in every state except IDLE
- GrantId  output  2  index of the current/last granted requester
- Shadow1  output  12  last successfully loaded DAC1 value
- Shadow2  output  12  last successfully loaded DAC2 value
- TimeoutSticky  output  1  set on any timeout; cleared by ClearError
- ClearError  input  1  synchronous clear of TimeoutSticky

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, timeout counter 0.
- States: IDLE, ISSUE, WAIT, COMPLETE.
- IDLE
  - If Enable=1 and any ReqValid is set, pick the first set bit searching from the pointer upward, mod 3.
  - Latch that requester's select and data into LoadDacSelect, Dac1Data and Dac2Data; set GrantId.
  - If the latched select = 00: go to COMPLETE with error, with no DAC access.
  - Otherwise go to ISSUE.
- ISSUE
  - DacLoadStart=1 for exactly this one cycle.
  - Clear the timeout counter. Go to WAIT.
- WAIT
  - Timeout counter increments every cycle.
  - DacLoadDone=1: go to COMPLETE, success.
  - Counter reaches TIMEOUT_CYCLES-1 without done: go to COMPLETE, error; set TimeoutSticky.
  - DacLoadDone and terminal count in the same cycle: treat as success.
- COMPLETE
  - ReqDone[GrantId]=1 for one cycle. ReqError[GrantId]=1 on error.
  - On success: select 01 updates Shadow1; 10 updates Shadow2; 11 updates both.
  - Pointer becomes GrantId+1 mod 3. Go to IDLE.
- Latency: grant to DacLoadStart = 1 cycle. DacLoadDone to ReqDone = 1 cycle. Minimum 1 IDLE cycle between consecutive grants, so the controller always sees start while it is idle.
- DacLoadDone is ignored outside WAIT: no state change and no shadow update.
- Requester data is sampled only at grant. Changes while granted are ignored. Dropping ReqValid mid-service does not abort the load; ReqDone still pulses.
- After ReqDone, a requester still holding ReqValid is re-arbitrated normally behind the other requesters.
- Enable=0 blocks only the IDLE→ISSUE transition.
- ClearError and a timeout in the same cycle: set wins.
- Reset mid-operation: everything returns to reset values immediately. No ReqDone is generated for the aborted grant.

Test Plan:
- Single request: req0, sel=01, data1=0x5A3; controller model returns done 40 cycles after start → DacLoadStart 1 cycle after grant; LoadDacSelect=01, Dac1Data=0x5A3; ReqDone[0] 1 cycle after done; Shadow1=0x5A3; ReqError=0.
- Round robin: all three requests held continuously → grant order 0,1,2,0,1,2; each ReqDone pulses once per service; never two starts without an intervening done.
- Both channels: req1, sel=11, data1=0x123, data2=0xABC → Shadow1=0x123 and Shadow2=0xABC after done; Shadow values unchanged before done.
- Illegal select: req2, sel=00 → no DacLoadStart; ReqDone[2] and ReqError[2] within 2 cycles of grant.
- Timeout: TIMEOUT_CYCLES=16, done never arrives → ReqError[0] at cycle 16 after start; TimeoutSticky=1, shadows unchanged; ClearError → TimeoutSticky=0.
- Reset in WAIT, and Enable=0 while requests pending → reset returns all outputs to 0 with no ReqDone; Enable=0 produces no start until Enable returns to 1.

Source files
------------

// File: rtl/dac_load_arbiter.sv
// Round-robin arbiter that shares one TLV5618 load controller among three requesters.
// It applies a per-load timeout and keeps shadow copies of the last DAC values loaded successfully.
module dac_load_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_WIDTH  = 13
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        Enable,
  input  logic [2:0]  ReqValid,
  input  logic [5:0]  ReqSelect,
  input  logic [35:0] ReqDac1Data,
  input  logic [35:0] ReqDac2Data,
  output logic [2:0]  ReqDone,
  output logic [2:0]  ReqError,
  output logic        DacLoadStart,
  output logic [1:0]  LoadDacSelect,
  output logic [11:0] Dac1Data,
  output logic [11:0] Dac2Data,
  input  logic        DacLoadDone,
  output logic        Busy,
  output logic [1:0]  GrantId,
  output logic [11:0] Shadow1,
  output logic [11:0] Shadow2,
  output logic        TimeoutSticky,
  input  logic        ClearError
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] WAIT     = 2'd2;
  localparam logic [1:0] COMPLETE = 2'd3;

  localparam logic [TIMEOUT_WIDTH-1:0] TERMINAL = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]               state;
  logic [1:0]               rrPtr;
  logic [TIMEOUT_WIDTH-1:0] timeoutCnt;
  logic [TIMEOUT_WIDTH-1:0] cntInc;
  logic                     errFlag;
  logic                     timeoutHit;

  // Per-requester views, padded to four entries so a 2-bit index is always in range
  logic [1:0]  reqSel   [4];
  logic [11:0] reqData1 [4];
  logic [11:0] reqData2 [4];
  logic [3:0]  validPad;

  logic [1:0] cand0;
  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [1:0] pick;
  logic       anyReq;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gUnpack
      assign reqSel[gi]   = ReqSelect[2*gi +: 2];
      assign reqData1[gi] = ReqDac1Data[12*gi +: 12];
      assign reqData2[gi] = ReqDac2Data[12*gi +: 12];
    end
  endgenerate

  assign reqSel[3]   = 2'b00;
  assign reqData1[3] = 12'd0;
  assign reqData2[3] = 12'd0;
  assign validPad    = {1'b0, ReqValid};

  function automatic logic [1:0] nextIdx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Search order starts at the pointer and wraps modulo 3
  always_comb begin
    cand0  = rrPtr;
    cand1  = nextIdx(cand0);
    cand2  = nextIdx(cand1);
    anyReq = |ReqValid;
    if (validPad[cand0])      pick = cand0;
    else if (validPad[cand1]) pick = cand1;
    else                      pick = cand2;
  end

  assign cntInc     = timeoutCnt + TIMEOUT_WIDTH'(1);
  assign timeoutHit = (state == WAIT) && !DacLoadDone && (cntInc == TERMINAL);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      rrPtr         <= 2'd0;
      timeoutCnt    <= '0;
      errFlag       <= 1'b0;
      GrantId       <= 2'd0;
      LoadDacSelect <= 2'b00;
      Dac1Data      <= 12'd0;
      Dac2Data      <= 12'd0;
      Shadow1       <= 12'd0;
      Shadow2       <= 12'd0;
      TimeoutSticky <= 1'b0;
    end else begin
      // A timeout in the same cycle as ClearError leaves the flag set
      TimeoutSticky <= (TimeoutSticky & ~ClearError) | timeoutHit;
      case (state)
        IDLE: begin
          if (Enable && anyReq) begin
            GrantId       <= pick;
            LoadDacSelect <= reqSel[pick];
            Dac1Data      <= reqData1[pick];
            Dac2Data      <= reqData2[pick];
            if (reqSel[pick] == 2'b00) begin
              errFlag <= 1'b1;
              state   <= COMPLETE;
            end else begin
              errFlag <= 1'b0;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          timeoutCnt <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          timeoutCnt <= cntInc;
          if (DacLoadDone) begin
            errFlag <= 1'b0;
            state   <= COMPLETE;
            if (LoadDacSelect[0]) Shadow1 <= Dac1Data;
            if (LoadDacSelect[1]) Shadow2 <= Dac2Data;
          end else if (timeoutHit) begin
            errFlag <= 1'b1;
            state   <= COMPLETE;
          end
        end
        default: begin
          rrPtr <= nextIdx(GrantId);
          state <= IDLE;
        end
      endcase
    end
  end

  assign DacLoadStart = (state == ISSUE);
  assign Busy         = (state != IDLE);

  generate
    for (gi = 0; gi < 3; gi++) begin : gDone
      assign ReqDone[gi]  = (state == COMPLETE) && (GrantId == 2'(gi));
      assign ReqError[gi] = (state == COMPLETE) && (GrantId == 2'(gi)) && errFlag;
    end
  endgenerate

endmodule

// File: tb/tb_dac_load_arbiter.sv
// Directed bench for dac_load_arbiter: a timeline-level reference model checked every cycle,
// plus literal expectations for latency, grant order and shadow contents.
module tb_dac_load_arbiter;

  localparam int T  = 48;
  localparam int TW = 6;

  logic        Clk;
  logic        reset_n;
  logic        Enable;
  logic [2:0]  ReqValid;
  logic [5:0]  ReqSelect;
  logic [35:0] ReqDac1Data;
  logic [35:0] ReqDac2Data;
  logic [2:0]  ReqDone;
  logic [2:0]  ReqError;
  logic        DacLoadStart;
  logic [1:0]  LoadDacSelect;
  logic [11:0] Dac1Data;
  logic [11:0] Dac2Data;
  logic        DacLoadDone;
  logic        Busy;
  logic [1:0]  GrantId;
  logic [11:0] Shadow1;
  logic [11:0] Shadow2;
  logic        TimeoutSticky;
  logic        ClearError;

  dac_load_arbiter #(.TIMEOUT_CYCLES(T), .TIMEOUT_WIDTH(TW)) dut (
    .Clk(Clk), .reset_n(reset_n), .Enable(Enable), .ReqValid(ReqValid),
    .ReqSelect(ReqSelect), .ReqDac1Data(ReqDac1Data), .ReqDac2Data(ReqDac2Data),
    .ReqDone(ReqDone), .ReqError(ReqError), .DacLoadStart(DacLoadStart),
    .LoadDacSelect(LoadDacSelect), .Dac1Data(Dac1Data), .Dac2Data(Dac2Data),
    .DacLoadDone(DacLoadDone), .Busy(Busy), .GrantId(GrantId),
    .Shadow1(Shadow1), .Shadow2(Shadow2), .TimeoutSticky(TimeoutSticky),
    .ClearError(ClearError)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Controller stand-in: done pulse doneDelay cycles after each start (0 = never)
  int doneDelay    = 40;
  int doneAt       = -1;
  int strayAt      = -1;
  int startCount   = 0;
  int lastStartCyc = -1;

  initial begin
    forever begin
      @(negedge Clk);
      if (DacLoadStart) begin
        startCount++;
        lastStartCyc = cyc;
        doneAt = (doneDelay > 0) ? cyc + doneDelay : -1;
      end
    end
  end

  initial begin
    DacLoadDone = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      DacLoadDone = (cyc == doneAt) || (cyc == strayAt);
    end
  end

  // Reference model: one grant at a time, described by its grant cycle and its end cycle
  bit          mActive;
  bit          mErr;
  bit          mSticky;
  int          mGrant;
  int          mEnd;
  int          mWho;
  int          mPtr;
  logic [1:0]  mSel;
  logic [11:0] mD1;
  logic [11:0] mD2;
  logic [11:0] mSh1;
  logic [11:0] mSh2;
  int          doneOrder[$];
  bit          outstanding;

  task automatic modelReset();
    mActive = 0; mErr = 0; mSticky = 0; mGrant = 0; mEnd = -1;
    mWho = 0; mPtr = 0; mSel = 2'b00; mD1 = 12'd0; mD2 = 12'd0;
    mSh1 = 12'd0; mSh2 = 12'd0; outstanding = 0;
  endtask

  initial begin
    int c;
    bit timeoutNow;
    logic [2:0] eDone;
    modelReset();
    forever begin
      @(negedge Clk);
      c = cyc;
      if (!reset_n) begin
        modelReset();
        chk("reset_ctrl", {ReqDone, ReqError, DacLoadStart, Busy, TimeoutSticky, GrantId, LoadDacSelect}, 64'd0);
        chk("reset_data", {Dac1Data, Dac2Data, Shadow1, Shadow2}, 64'd0);
      end else begin
        eDone = (mActive && c == mEnd) ? 3'(1 << mWho) : 3'b000;
        chk("ReqDone", ReqDone, eDone);
        chk("ReqError", ReqError, mErr ? eDone : 3'b000);
        chk("DacLoadStart", DacLoadStart, mActive && c == mGrant + 1 && mSel != 2'b00);
        chk("Busy", Busy, mActive);
        chk("GrantId", GrantId, mWho);
        chk("LoadDacSelect", LoadDacSelect, mSel);
        chk("Dac1Data", Dac1Data, mD1);
        chk("Dac2Data", Dac2Data, mD2);
        chk("Shadow1", Shadow1, mSh1);
        chk("Shadow2", Shadow2, mSh2);
        chk("TimeoutSticky", TimeoutSticky, mSticky);

        if (DacLoadStart) begin
          chk("one_start_per_done", outstanding, 1'b0);
          outstanding = 1;
        end
        if (|ReqDone) begin
          outstanding = 0;
          doneOrder.push_back(GrantId);
          $display("TXN cycle %0d req %0d sel %b d1 %03h d2 %03h err %0b",
                   c, GrantId, LoadDacSelect, Dac1Data, Dac2Data, |ReqError);
        end

        timeoutNow = 0;
        if (mActive) begin
          if (c == mEnd) begin
            mActive = 0;
            mPtr = (mWho + 1) % 3;
          end else if (mEnd < 0 && c >= mGrant + 2) begin
            if (DacLoadDone) begin
              mEnd = c + 1;
              mErr = 0;
              if (mSel[0]) mSh1 = mD1;
              if (mSel[1]) mSh2 = mD2;
            end else if (c == mGrant + T) begin
              mEnd = c + 1;
              mErr = 1;
              timeoutNow = 1;
            end
          end
        end else if (Enable && |ReqValid) begin
          for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (mPtr + k) % 3;
            if (ReqValid[idx]) begin
              mWho = idx;
              break;
            end
          end
          mActive = 1;
          mGrant  = c;
          mSel    = ReqSelect[2*mWho +: 2];
          mD1     = ReqDac1Data[12*mWho +: 12];
          mD2     = ReqDac2Data[12*mWho +: 12];
          mErr    = (mSel == 2'b00);
          mEnd    = (mSel == 2'b00) ? c + 1 : -1;
        end
        if (timeoutNow) mSticky = 1;
        else if (ClearError) mSticky = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic setReq(input int i, input logic [1:0] sel, input logic [11:0] d1, input logic [11:0] d2);
    ReqSelect[2*i +: 2]    = sel;
    ReqDac1Data[12*i +: 12] = d1;
    ReqDac2Data[12*i +: 12] = d2;
  endtask

  task automatic waitDone(input int i, input int budget, output int dcyc, output logic derr, output logic dst);
    dcyc = -1; derr = 1'b0; dst = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge Clk);
      if (ReqDone[i]) begin
        dcyc = cyc;
        derr = ReqError[i];
        dst  = TimeoutSticky;
        break;
      end
    end
    chk("wait_done_in_budget", dcyc >= 0, 1'b1);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, dcyc, sc, cnt;
    logic derr, dst;
    int expOrder[6];
    expOrder = '{0, 1, 2, 0, 1, 2};

    reset_n = 1'b0; Enable = 1'b0; ReqValid = 3'b000; ReqSelect = 6'd0;
    ReqDac1Data = 36'd0; ReqDac2Data = 36'd0; ClearError = 1'b0;
    step(3);
    reset_n = 1'b1;
    Enable  = 1'b1;
    step(2);

    // Single load on DAC1
    doneDelay = 40;
    setReq(0, 2'b01, 12'h5A3, 12'h000);
    ReqValid = 3'b001;
    c0 = cyc;
    waitDone(0, 100, dcyc, derr, dst);
    ReqValid = 3'b000;
    chk("t1_start_latency", lastStartCyc - c0, 1);
    chk("t1_done_latency", dcyc - lastStartCyc, 41);
    chk("t1_error", derr, 1'b0);
    chk("t1_shadow1", Shadow1, 12'h5A3);

    // Both channels; data changes while granted are ignored
    setReq(1, 2'b11, 12'h123, 12'hABC);
    ReqValid = 3'b010;
    step(10);
    chk("t3_shadow1_before", Shadow1, 12'h5A3);
    chk("t3_shadow2_before", Shadow2, 12'h000);
    setReq(1, 2'b11, 12'hFFF, 12'hEEE);
    waitDone(1, 100, dcyc, derr, dst);
    ReqValid = 3'b000;
    chk("t3_shadow1", Shadow1, 12'h123);
    chk("t3_shadow2", Shadow2, 12'hABC);

    // Stray done while idle
    strayAt = cyc + 2;
    step(5);
    chk("stray_no_busy", Busy, 1'b0);

    // Illegal select
    setReq(2, 2'b00, 12'h321, 12'h654);
    ReqValid = 3'b100;
    sc = startCount;
    c0 = cyc;
    waitDone(2, 10, dcyc, derr, dst);
    ReqValid = 3'b000;
    chk("t4_latency", dcyc - c0, 1);
    chk("t4_error", derr, 1'b1);
    chk("t4_no_start", startCount - sc, 0);

    // Round robin with all three held
    doneDelay = 5;
    setReq(0, 2'b01, 12'h111, 12'h000);
    setReq(1, 2'b10, 12'h000, 12'h222);
    setReq(2, 2'b11, 12'h333, 12'h444);
    doneOrder.delete();
    ReqValid = 3'b111;
    cnt = 0;
    for (int n = 0; n < 300 && cnt < 6; n++) begin
      @(negedge Clk);
      if (|ReqDone) cnt++;
    end
    @(posedge Clk);
    #1;
    ReqValid = 3'b000;
    chk("rr_count", doneOrder.size(), 6);
    for (int k = 0; k < 6 && k < doneOrder.size(); k++) chk("rr_order", doneOrder[k], expOrder[k]);
    chk("rr_shadow1", Shadow1, 12'h333);
    chk("rr_shadow2", Shadow2, 12'h444);
    step(3);

    // Timeout, then clear
    doneDelay = 0;
    setReq(0, 2'b10, 12'h000, 12'h777);
    ReqValid = 3'b001;
    waitDone(0, 100, dcyc, derr, dst);
    ReqValid = 3'b000;
    chk("to_latency", dcyc - lastStartCyc, T);
    chk("to_error", derr, 1'b1);
    chk("to_sticky", dst, 1'b1);
    chk("to_shadow2", Shadow2, 12'h444);
    ClearError = 1'b1;
    step(1);
    ClearError = 1'b0;
    step(1);
    chk("clear_sticky", TimeoutSticky, 1'b0);

    // Timeout while ClearError is held: set wins
    ClearError = 1'b1;
    setReq(1, 2'b01, 12'h0AA, 12'h000);
    ReqValid = 3'b010;
    waitDone(1, 100, dcyc, derr, dst);
    ReqValid   = 3'b000;
    ClearError = 1'b0;
    chk("set_wins", dst, 1'b1);
    chk("set_wins_then_clear", TimeoutSticky, 1'b0);

    // Reset in WAIT: no ReqDone for the aborted grant
    doneDelay = 40;
    setReq(1, 2'b01, 12'h9AB, 12'h000);
    ReqValid = 3'b010;
    step(10);
    reset_n  = 1'b0;
    ReqValid = 3'b000;
    step(2);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_shadow1", Shadow1, 12'h000);
    reset_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge Clk);
      if (|ReqDone) cnt++;
    end
    step(1);
    chk("rst_no_done", cnt, 0);

    // Enable low holds off grants
    Enable = 1'b0;
    setReq(2, 2'b01, 12'h0F0, 12'h000);
    ReqValid = 3'b100;
    sc = startCount;
    step(20);
    chk("en_no_start", startCount - sc, 0);
    chk("en_not_busy", Busy, 1'b0);
    Enable = 1'b1;
    c0 = cyc;
    waitDone(2, 100, dcyc, derr, dst);
    ReqValid = 3'b000;
    chk("en_latency", dcyc - c0, 42);
    chk("en_shadow1", Shadow1, 12'h0F0);
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
